noc_switch_arbiter: RTL and testbench
=====================================

# noc_switch_arbiter

Parametrised switch-allocation and output-register stage for the mesh router. It generalises the fixed four/five-port allocator to NUM_PORTS ports and adds a selectable round-robin or fixed-priority policy plus a saturating contention counter. It sits after route computation, which supplies data and a one-hot output request per input port. It drives the router's registered output links, which are subject to downstream `full` back-pressure.

## Interface
- NUM_PORTS, 5, number of input and output ports; index 0 = L, then N, E, S, W.
- DATASIZE, 40, flit width: src 4, dst 4, timestamp 8, data 22, type 2.
- RR_MODE, 1, 1 = per-output round-robin; 0 = fixed priority, lowest input index wins.
- PW, $clog2(NUM_PORTS), width of a round-robin pointer.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  NUM_PORTS*DATASIZE  input i flit in slice [i*DATASIZE +: DATASIZE].
- in_req  in  NUM_PORTS*NUM_PORTS  input i one-hot output request in [i*NUM_PORTS +: NUM_PORTS]; all-zero = idle.
- in_ready  out  NUM_PORTS  combinational grant; input i's flit is consumed at this clock edge.
- out_data  out  NUM_PORTS*DATASIZE  registered output flit per port.
- out_valid  out  NUM_PORTS  registered one-cycle write strobe per output.
- out_full  in  NUM_PORTS  downstream full per output.
- cnt_clr  in  1  synchronous clear of conflict_cnt.
- conflict_cnt  out  16  saturating count of contention cycles.

## Operation
- Request decode: each input requests at most one output. If more than one bit is set, the lowest set bit is used; the bench flags this as a protocol error.
- Per output o, the candidates are the inputs i with a decoded request for o. Any input may target any output, including loopback i == o.
- Output o grants only when out_full[o] == 0.
- RR_MODE=1 search order: start at ptr[o], then ptr[o]+1 and onward, wrapping modulo NUM_PORTS. The first candidate found wins.
- RR_MODE=1 pointer update: on a grant to input i, ptr[o] <= (i+1) mod NUM_PORTS. With no grant, ptr[o] holds.
- RR_MODE=0: the lowest-index candidate wins and the pointers are unused, remaining at 0.
- in_ready[i] = 1 iff input i is granted this cycle. An input gets at most one grant because its decoded request is one-hot.
- Output register, out_full[o] == 0: out_valid[o] <= (grant to o); out_data slice <= the granted input's in_data when granted, otherwise it holds.
- Output register, out_full[o] == 1: out_valid[o] <= 0; out_data holds; no grant; ptr[o] holds.
- out_valid is a strobe, never held across cycles for the same flit. Downstream full must reserve at least one slot for an in-flight flit.
- Contention cycle: a cycle in which at least one input has a decoded request and in_ready for it is 0, whether it lost arbitration or its output is full.
- conflict_cnt: +1 per contention cycle, saturating at 16'hFFFF. cnt_clr has priority over increment and loads 0.

## Timing
- Latency: in_req and in_data sampled in cycle N give out_valid and out_data in cycle N+1.
- Throughput: one flit per output per cycle while not full, and all outputs operate in parallel.
- in_ready is combinational from in_req, out_full and registered pointers, with no combinational path from in_data.
- out_full at edge N blocks grants in cycle N. A flit already registered is still presented in that cycle.
- Reset values, asynchronous on rst rising and held while rst=1:
  - out_valid = 0, out_data = 0, all ptr = 0, conflict_cnt = 0.
  - in_ready is forced to 0.
- Reset mid-transfer: the flit granted in the same cycle is dropped. Upstream must treat reset as global.
- Simultaneous full release and requests: a grant occurs in the same cycle out_full falls, and the pointer resumes from its held value.
- Wrap-around: with ptr = NUM_PORTS-1 and a grant to input NUM_PORTS-1, ptr becomes 0.

## Test plan
- Reset: drive traffic, then pulse rst mid-stream. All out_valid, out_data, conflict_cnt and in_ready go to 0 immediately. Afterwards the first grant from contention at output 1 goes to input 0.
- Single flit: input 2 requests output 3 with data 40'hA5. in_ready[2]=1 in the same cycle; next cycle out_valid[3]=1 and out_data[3] = 40'hA5; no other out_valid asserts.
- Round-robin: inputs 0, 1 and 4 request output 1 for 6 cycles.
  - Grant order is 0, 1, 4, 0, 1, 4.
  - conflict_cnt = 6.
- Fixed priority (RR_MODE=0): same stimulus as the round-robin case. Input 0 is granted every cycle, inputs 1 and 4 never; conflict_cnt = 6.
- Back-pressure: out_full[1]=1 for 3 cycles while inputs 0 and 1 request output 1.
  - During those cycles: in_ready = 0, out_valid[1] = 0 and out_data[1] holds.
  - After release: the grant resumes from the held pointer.
- Counter: hold contention for 70000 cycles and conflict_cnt stays at 16'hFFFF. Assert cnt_clr during contention and conflict_cnt = 0 next cycle, then 1 the cycle after.

Source files
------------

// File: rtl/noc_switch_arbiter.sv
// Switch allocator and output-register stage: per-output round-robin or fixed-priority
// arbitration over one-hot input requests, registered output links, saturating contention counter.
module noc_switch_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int DATASIZE  = 40,
  parameter int RR_MODE   = 1,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*DATASIZE-1:0]  in_data,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_req,
  output logic [NUM_PORTS-1:0]           in_ready,
  output logic [NUM_PORTS*DATASIZE-1:0]  out_data,
  output logic [NUM_PORTS-1:0]           out_valid,
  input  logic [NUM_PORTS-1:0]           out_full,
  input  logic                          cnt_clr,
  output logic [15:0]                   conflict_cnt
);

  localparam int N = NUM_PORTS;
  localparam int D = DATASIZE;

  logic [N-1:0][N-1:0] dec_mat;  // [input][output], lowest request bit only
  logic [N-1:0][N-1:0] gnt_mat;  // [output][input]
  logic [N-1:0]        req_any;
  logic [N-1:0]        ready_raw;
  logic                contention;
  logic [15:0]         cnt_reg;

  genvar gi;

  generate
    for (gi = 0; gi < N; gi++) begin : g_in
      logic [N-1:0] row;
      assign row          = in_req[gi*N +: N];
      assign dec_mat[gi]  = row & (~row + N'(1));
      assign req_any[gi]  = |row;
    end

    for (gi = 0; gi < N; gi++) begin : g_out
      logic [N-1:0]  cand;
      logic [N-1:0]  gnt;
      logic          found;
      logic [PW-1:0] ptr_reg;
      logic [PW-1:0] ptr_next;
      logic [D-1:0]  sel_data;
      logic [D-1:0]  data_reg;
      logic          valid_reg;

      always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++) cand[i] = dec_mat[i][gi];
      end

      // Two passes: inputs at or above the pointer first, then the wrapped-around ones.
      always_comb begin
        gnt   = '0;
        found = 1'b0;
        if (!out_full[gi]) begin
          for (int i = 0; i < N; i++) begin
            if (cand[i] && (i >= int'(ptr_reg)) && !found) begin
              gnt[i] = 1'b1;
              found  = 1'b1;
            end
          end
          for (int i = 0; i < N; i++) begin
            if (cand[i] && (i < int'(ptr_reg)) && !found) begin
              gnt[i] = 1'b1;
              found  = 1'b1;
            end
          end
        end
      end

      always_comb begin
        ptr_next = ptr_reg;
        for (int i = 0; i < N; i++) begin
          if (gnt[i]) ptr_next = (i == N-1) ? '0 : PW'(i + 1);
        end
      end

      always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
          if (gnt[i]) sel_data = in_data[i*D +: D];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ptr_reg   <= '0;
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          if (RR_MODE != 0) ptr_reg <= ptr_next;
          valid_reg <= |gnt;
          if (|gnt) data_reg <= sel_data;
        end
      end

      assign gnt_mat[gi]         = gnt;
      assign out_valid[gi]       = valid_reg;
      assign out_data[gi*D +: D] = data_reg;
    end
  endgenerate

  always_comb begin
    ready_raw = '0;
    for (int o = 0; o < N; o++) ready_raw = ready_raw | gnt_mat[o];
  end

  // A flit presented during reset must not be seen as consumed.
  assign in_ready   = rst ? '0 : ready_raw;
  assign contention = |(req_any & ~ready_raw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_clr) begin
      cnt_reg <= '0;
    end else if (contention && (cnt_reg != 16'hFFFF)) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_noc_switch_arbiter.sv
// Bench for noc_switch_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are compared against a behavioural per-output arbitration model.
module tb_noc_switch_arbiter;

  localparam int N = 5;
  localparam int D = 40;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*D-1:0] in_data = '0;
  logic [N*N-1:0] in_req = '0;
  logic [N-1:0]   out_full = '0;
  logic           cnt_clr = 1'b0;

  logic [N-1:0]   rdy_a, rdy_b, oval_a, oval_b;
  logic [N*D-1:0] odata_a, odata_b;
  logic [15:0]    cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  noc_switch_arbiter #(.NUM_PORTS(N), .DATASIZE(D), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_req(in_req), .in_ready(rdy_a),
    .out_data(odata_a), .out_valid(oval_a), .out_full(out_full), .cnt_clr(cnt_clr),
    .conflict_cnt(cnt_a));

  noc_switch_arbiter #(.NUM_PORTS(N), .DATASIZE(D), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_req(in_req), .in_ready(rdy_b),
    .out_data(odata_b), .out_valid(oval_b), .out_full(out_full), .cnt_clr(cnt_clr),
    .conflict_cnt(cnt_b));

  // ---------------- reference model (mode 0 = round-robin, 1 = fixed priority)
  int          m_ptr [N];
  logic [D-1:0] m_data [2][N];
  bit          m_valid [2][N];
  int          m_cnt [2];
  int          win [2][N];
  logic [N-1:0] exp_rdy [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int target(int i);
    for (int o = 0; o < N; o++) if (in_req[i*N+o]) return o;
    return -1;
  endfunction

  // Winner = requesting input with the smallest distance from the pointer (RR) or smallest index.
  function automatic int winner(int m, int o);
    int best = -1;
    int bestd = N;
    if (out_full[o]) return -1;
    for (int i = 0; i < N; i++) begin
      if (target(i) == o) begin
        int d = (m == 0) ? ((i - m_ptr[o] + N) % N) : i;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic m_reset();
    for (int o = 0; o < N; o++) begin
      m_ptr[o] = 0;
      for (int m = 0; m < 2; m++) begin
        m_data[m][o]  = '0;
        m_valid[m][o] = 1'b0;
      end
    end
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic m_comb();
    for (int m = 0; m < 2; m++) begin
      exp_rdy[m] = '0;
      for (int o = 0; o < N; o++) begin
        win[m][o] = winner(m, o);
        if (win[m][o] >= 0) exp_rdy[m][win[m][o]] = 1'b1;
      end
    end
  endtask

  task automatic m_seq();
    for (int m = 0; m < 2; m++) begin
      bit waiting = 1'b0;
      for (int i = 0; i < N; i++)
        if (target(i) >= 0 && !exp_rdy[m][i]) waiting = 1'b1;
      for (int o = 0; o < N; o++) begin
        if (win[m][o] >= 0) begin
          m_valid[m][o] = 1'b1;
          m_data[m][o]  = in_data[win[m][o]*D +: D];
          if (m == 0) m_ptr[o] = (win[m][o] + 1) % N;
        end else begin
          m_valid[m][o] = 1'b0;
        end
      end
      if (cnt_clr) m_cnt[m] = 0;
      else if (waiting && m_cnt[m] < 65535) m_cnt[m]++;
    end
  endtask

  task automatic chk_outputs();
    logic [N-1:0] ev0, ev1;
    for (int o = 0; o < N; o++) begin
      ev0[o] = m_valid[0][o];
      ev1[o] = m_valid[1][o];
      chk($sformatf("out_data_rr[%0d]", o), 64'(odata_a[o*D +: D]), 64'(m_data[0][o]));
      chk($sformatf("out_data_fp[%0d]", o), 64'(odata_b[o*D +: D]), 64'(m_data[1][o]));
    end
    chk("out_valid_rr", 64'(oval_a), 64'(ev0));
    chk("out_valid_fp", 64'(oval_b), 64'(ev1));
    chk("conflict_cnt_rr", 64'(cnt_a), 64'(m_cnt[0]));
    chk("conflict_cnt_fp", 64'(cnt_b), 64'(m_cnt[1]));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(output logic [N-1:0] rdy, output logic [N-1:0] vld);
    m_comb();
    #1;
    chk("in_ready_rr", 64'(rdy_a), 64'(exp_rdy[0]));
    chk("in_ready_fp", 64'(rdy_b), 64'(exp_rdy[1]));
    rdy = rdy_a;
    @(posedge clk);
    m_seq();
    #1;
    chk_outputs();
    vld = oval_a;
    @(negedge clk);
  endtask

  // Asserts reset at a falling edge with whatever traffic is present.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid_rr", 64'(oval_a), 64'd0);
    chk("rst_out_valid_fp", 64'(oval_b), 64'd0);
    chk("rst_out_data_rr", 64'(odata_a != '0), 64'd0);
    chk("rst_out_data_fp", 64'(odata_b != '0), 64'd0);
    chk("rst_cnt_rr", 64'(cnt_a), 64'd0);
    chk("rst_cnt_fp", 64'(cnt_b), 64'd0);
    chk("rst_in_ready_rr", 64'(rdy_a), 64'd0);
    chk("rst_in_ready_fp", 64'(rdy_b), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_req   = '0;
    out_full = '0;
    cnt_clr  = 1'b0;
    m_reset();
  endtask

  function automatic logic [N*N-1:0] rq(int i, int o);
    logic [N*N-1:0] r = '0;
    r[i*N+o] = 1'b1;
    return r;
  endfunction

  typedef struct {
    logic [N*N-1:0] req;
    logic [N-1:0]   full;
    logic [D-1:0]   base;
    logic [N-1:0]   exp_ready;
    logic [N-1:0]   exp_valid;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [N-1:0] r, v;
    logic [D-1:0] held;
    int order [6];

    vecs[0] = '{rq(2,3), 5'b00000, 40'hA3, 5'b00100, 5'b01000};
    vecs[1] = '{'0, 5'b00000, 40'h10, 5'b00000, 5'b00000};
    vecs[2] = '{rq(1,1) | rq(4,4), 5'b00000, 40'h20, 5'b10010, 5'b10010};
    vecs[3] = '{rq(0,2) | rq(0,4), 5'b00000, 40'h30, 5'b00001, 5'b00100};
    vecs[4] = '{rq(0,0) | rq(1,0) | rq(2,0) | rq(3,0) | rq(4,0), 5'b00001, 40'h40, 5'b00000, 5'b00000};
    vecs[5] = '{rq(0,0) | rq(1,0) | rq(2,0) | rq(3,0) | rq(4,0), 5'b00000, 40'h50, 5'b00001, 5'b00001};
    vecs[6] = '{rq(3,0), 5'b00000, 40'h60, 5'b01000, 5'b00001};
    vecs[7] = '{rq(4,0) | rq(0,0), 5'b00000, 40'h70, 5'b10000, 5'b00001};
    vecs[8] = '{rq(4,0) | rq(0,0), 5'b00000, 40'h80, 5'b00001, 5'b00001};

    m_reset();
    @(negedge clk);
    do_reset();

    // table-driven vectors from a fresh reset
    for (int k = 0; k < 9; k++) begin
      in_req   = vecs[k].req;
      out_full = vecs[k].full;
      for (int i = 0; i < N; i++) in_data[i*D +: D] = vecs[k].base + D'(i);
      for (int i = 0; i < N; i++)
        if ($countones(in_req[i*N +: N]) > 1)
          $display("protocol error: input %0d multi-hot request %b (vector %0d)", i, in_req[i*N +: N], k);
      cycle(r, v);
      chk($sformatf("vec%0d_ready", k), 64'(r), 64'(vecs[k].exp_ready));
      chk($sformatf("vec%0d_valid", k), 64'(v), 64'(vecs[k].exp_valid));
      if (k == 0) chk("single_flit_data", 64'(odata_a[3*D +: D]), 64'h00000000A5);
    end

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      in_req = '0;
      for (int i = 0; i < N; i++) begin
        in_data[i*D +: D] = {$urandom, $urandom};
        if ($urandom_range(0, 9) < 7) in_req[i*N + $urandom_range(0, N-1)] = 1'b1;
      end
      for (int o = 0; o < N; o++) out_full[o] = ($urandom_range(0, 3) == 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      cycle(r, v);
    end

    // reset mid-stream with traffic still applied
    do_reset();

    // round-robin vs fixed priority on output 1
    order = '{0, 1, 4, 0, 1, 4};
    in_req = rq(0,1) | rq(1,1) | rq(4,1);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) in_data[i*D +: D] = D'(100 + 10*k + i);
      cycle(r, v);
      chk($sformatf("rr_order[%0d]", k), 64'(r), 64'(1) << order[k]);
      chk($sformatf("fp_grant[%0d]", k), 64'(rdy_b), 64'd1);
    end
    chk("rr_cnt_6", 64'(cnt_a), 64'd6);
    chk("fp_cnt_6", 64'(cnt_b), 64'd6);

    // back-pressure on output 1
    in_req = rq(0,1) | rq(1,1);
    cycle(r, v);
    chk("bp_pre_grant", 64'(r), 64'b00001);
    held = odata_a[1*D +: D];
    out_full[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) in_data[i*D +: D] = D'(500 + i + 10*k);
      cycle(r, v);
      chk($sformatf("bp_ready[%0d]", k), 64'(r), 64'd0);
      chk($sformatf("bp_valid1[%0d]", k), 64'(v[1]), 64'd0);
      chk($sformatf("bp_hold[%0d]", k), 64'(odata_a[1*D +: D]), 64'(held));
    end
    out_full[1] = 1'b0;
    cycle(r, v);
    chk("bp_resume", 64'(r), 64'b00010);

    // saturation and clear
    do_reset();
    in_req = rq(0,1) | rq(1,1);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_rr", 64'(cnt_a), 64'hFFFF);
    chk("sat_fp", 64'(cnt_b), 64'hFFFF);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_rr", 64'(cnt_a), 64'd0);
    chk("clr_fp", 64'(cnt_b), 64'd0);
    @(negedge clk);
    cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_next_rr", 64'(cnt_a), 64'd1);
    chk("clr_next_fp", 64'(cnt_b), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
